pair_sequencer: RTL
===================

PAIR_SEQUENCER -- requirements
Module: pair_sequencer

Interface
REQ-001 Parameter NSLOTS, default 14, neighbor slots per bundle (2..32).
REQ-002 Parameter PW, default 114, particle record width in bits.
REQ-003 Parameter NULL_BIT, default 96, bit index within a record that marks the slot null when set.
REQ-004 Parameter CW, default 5, slot-index/count width; SHALL satisfy 2^CW > NSLOTS.
REQ-005 clk  in  1  single clock; all state changes on posedge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-007 in_valid  in  1  bundle offered.
REQ-008 in_ready  out  1  bundle accepted when in_valid & in_ready.
REQ-009 in_reference  in  PW  reference particle record.
REQ-010 in_neighbors  in  NSLOTS*PW  neighbor records; slot k occupies bits [k*PW +: PW].
REQ-011 flush  in  1  synchronous abort of the current bundle.
REQ-012 out_valid  out  1  pair offered.
REQ-013 out_ready  in  1  pair consumed when out_valid & out_ready.
REQ-014 out_reference  out  PW  buffered reference.
REQ-015 out_neighbor  out  PW  buffered neighbor of current slot.
REQ-016 out_idx  out  CW  slot index of current pair.
REQ-017 out_last  out  1  current pair is the final non-null pair of the bundle.
REQ-018 done  out  1  one-cycle pulse on bundle completion.
REQ-019 pair_count  out  CW  non-null pairs emitted for the most recent completed bundle.

Function
REQ-020 States: IDLE, SCAN, DONE; encoding free; out_valid, in_ready and done SHALL be decoded from registered state only (no combinational in->out paths).
REQ-021 IDLE: in_ready=1; on in_valid, capture reference, all NSLOTS records and a null mask (mask[k] = record k bit NULL_BIT); set idx=0, running count=0; go to SCAN.
REQ-022 SCAN, slot idx null: out_valid=0; advance idx by one per cycle.
REQ-023 SCAN, slot idx non-null: out_valid=1 with out_neighbor=slot idx, out_idx=idx; hold all outputs stable until out_ready; on handshake, increment count and advance idx.
REQ-024 SCAN exits to DONE in the cycle after idx=NSLOTS-1 is retired (null skipped or pair handshaken).
REQ-025 out_last=1 iff out_valid and no mask-clear slot exists above idx.
REQ-026 DONE: done=1 for exactly one cycle, pair_count updated to the bundle count in that same cycle, in_ready=0; next state IDLE.
REQ-027 Latency: bundle accepted at cycle T with j leading null slots -> first out_valid at T+1+j.
REQ-028 All-null bundle: no out_valid, done at T+1+NSLOTS, pair_count=0.
REQ-029 in_ready SHALL be 0 in SCAN and DONE; in_valid there is ignored and buffers unchanged.
REQ-030 flush in SCAN: next state DONE regardless of out_ready; a simultaneous out_ready handshake SHALL still be counted; pair_count reports pairs emitted so far.
REQ-031 flush in IDLE or DONE: no effect; in IDLE with in_valid, the bundle is accepted normally.
REQ-032 Count arithmetic unsigned CW bits; cannot overflow given REQ-004.
REQ-033 out_reference and out_neighbor are don't-care when out_valid=0 but SHALL not change while out_valid=1 and out_ready=0.

Reset
REQ-034 reset=0 asynchronously forces IDLE: in_ready=1, out_valid=0, out_last=0, done=0, pair_count=0, out_idx=0; buffers need not clear.
REQ-035 Reset mid-SCAN abandons the bundle with no done pulse; first posedge after release is in IDLE.

Verification (NSLOTS=14, PW=114)
REQ-036 No nulls, out_ready held 1 -> pairs idx 0..13 on consecutive cycles T+1..T+14, out_last only at idx 13, done at T+15, pair_count=14.
REQ-037 Slots 0,1,5,13 null, out_ready=1 -> first pair idx 2 at T+3, idx sequence 2,3,4,6..12, out_last at idx 12, pair_count=10.
REQ-038 All null -> no out_valid, done at T+15, pair_count=0, in_ready=1 at T+16.
REQ-039 Backpressure: out_ready=0 for 5 cycles at idx 3 -> outputs stable 5 cycles, idx 3 emitted once, final pair_count=14.
REQ-040 flush with out_ready=1 while presenting idx 6 -> done next cycle, pair_count=7; new bundle accepted in the following IDLE cycle.
REQ-041 reset=0 asserted mid-SCAN between clock edges -> out_valid drops immediately, no done, in_ready=1 after release.

Source files
------------

// File: rtl/pair_sequencer.sv
// pair_sequencer: buffers one reference plus NSLOTS neighbor records and emits the
// non-null (reference, neighbor) pairs in slot order over a valid/ready handshake,
// then pulses done with the number of pairs emitted.
module pair_sequencer #(
   parameter int unsigned NSLOTS   = 14,
   parameter int unsigned PW       = 114,
   parameter int unsigned NULL_BIT = 96,
   parameter int unsigned CW       = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PW-1:0]        in_reference,
   input  logic [NSLOTS*PW-1:0] in_neighbors,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PW-1:0]        out_reference,
   output logic [PW-1:0]        out_neighbor,
   output logic [CW-1:0]        out_idx,
   output logic                 out_last,
   output logic                 done,
   output logic [CW-1:0]        pair_count
);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   localparam logic [CW-1:0] LastIdx = CW'(NSLOTS - 1);
   localparam logic [CW-1:0] One     = CW'(1);

   state_e               state_q, state_d;
   logic [PW-1:0]        ref_q;
   logic [NSLOTS*PW-1:0] nbr_q;
   logic [NSLOTS-1:0]    mask_q, in_mask;
   logic [CW-1:0]        idx_q, idx_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [CW-1:0]        pair_count_q, pair_count_d;
   logic                 capture;
   logic                 cur_null, more_above, hs, retire;
   logic [PW-1:0]        cur_nbr;

   // Slot decode: null flags of the incoming bundle, and the buffered slot under idx
   always_comb begin
      in_mask    = '0;
      cur_null   = 1'b1;
      cur_nbr    = '0;
      more_above = 1'b0;
      for (int k = 0; k < NSLOTS; k++) begin
         in_mask[k] = in_neighbors[k*PW + NULL_BIT];
         if (idx_q == CW'(k)) begin
            cur_null = mask_q[k];
            cur_nbr  = nbr_q[k*PW +: PW];
         end
         if ((CW'(k) > idx_q) && !mask_q[k]) begin
            more_above = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and counter logic; a slot retires when null or when its pair is taken
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      pair_count_d = pair_count_q;
      capture      = 1'b0;
      hs           = (state_q == StScan) && !cur_null && out_ready;
      retire       = cur_null || out_ready;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               capture = 1'b1;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            cnt_d = cnt_q + CW'(hs);
            // flush still counts a pair handshaken in the same cycle
            if (flush || (retire && (idx_q == LastIdx))) begin
               state_d      = StDone;
               pair_count_d = cnt_d;
            end else if (retire) begin
               idx_d = idx_q + One;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Slot index, running count and reported count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q        <= '0;
         cnt_q        <= '0;
         pair_count_q <= '0;
      end else begin
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         pair_count_q <= pair_count_d;
      end
   end

   // Bundle buffers: loaded only on acceptance, contents irrelevant until then
   always_ff @(posedge clk) begin
      if (capture) begin
         ref_q  <= in_reference;
         nbr_q  <= in_neighbors;
         mask_q <= in_mask;
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      in_ready      = (state_q == StIdle);
      out_valid     = (state_q == StScan) && !cur_null;
      out_last      = (state_q == StScan) && !cur_null && !more_above;
      done          = (state_q == StDone);
      out_reference = ref_q;
      out_neighbor  = cur_nbr;
      out_idx       = idx_q;
      pair_count    = pair_count_q;
   end

endmodule
